// File: rtl/hermes_inject_arbiter.sv
// hermes_inject_arbiter: packet-granular round-robin sharing of one HermesNoC router local input port
// A grant spans header, size and payload flits so packets never interleave on the router port.
module hermes_inject_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int FLIT_SIZE = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_rx_i,
   input  logic [FLIT_SIZE-1:0] req_data_i [NUM_REQ],
   output logic [NUM_REQ-1:0]   req_credit_o,
   output logic                 rx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o,
   output logic [15:0]          pkt_cnt_o
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] owner, rr_ptr, sel;
   logic [FLIT_SIZE-1:0] remaining;
   logic found, xfer, release_pkt;
   // descending scan so the requester nearest rr_ptr is assigned last and wins
   always_comb begin
      found = 1'b0;
      sel = rr_ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_rx_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
            found = 1'b1;
            sel = IW'((int'(rr_ptr) + i) % NUM_REQ);
         end
   end
   always_ff @(posedge clk_i)
      state <= !rst_ni ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = found ? HEADER : IDLE;
         HEADER:  state_nxt = xfer ? SIZE : HEADER;
         SIZE:    state_nxt = !xfer ? SIZE : (data_o == '0) ? IDLE : PAYLOAD;
         PAYLOAD: state_nxt = release_pkt ? IDLE : PAYLOAD;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      busy_o = state != IDLE;
      rx_o = busy_o && req_rx_i[owner];
      data_o = busy_o ? req_data_i[owner] : '0;
      req_credit_o = credit_i ? grant_o : '0;
      xfer = rx_o && credit_i;
      release_pkt = xfer && ((state == SIZE && data_o == '0) ||
                             (state == PAYLOAD && remaining == FLIT_SIZE'(1)));
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         owner     <= '0;
         grant_o   <= '0;
         rr_ptr    <= '0;
         remaining <= '0;
         pkt_cnt_o <= '0;
      end else begin
         if (state == IDLE && found) begin
            owner   <= sel;
            grant_o <= NUM_REQ'(1) << sel;
         end
         if (release_pkt) begin
            grant_o   <= '0;
            rr_ptr    <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
         end
         if (xfer && state == SIZE) remaining <= data_o;
         else if (xfer && state == PAYLOAD) remaining <= remaining - FLIT_SIZE'(1);
      end
   end
endmodule

// File: tb/tb_hermes_inject_arbiter.sv
// tb_hermes_inject_arbiter: cycle vectors for directed corners plus random traffic against a packet-level model
// The model orders whole packets round-robin over sources with pending packets and concatenates their flits.
module tb_hermes_inject_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam logic [31:0] K0 = 32'hD0D0_0000, K1 = 32'hD1D1_0001, K2 = 32'hD2D2_0002;
   logic clk_i = 1'b0;
   logic rst_ni, rx_o, credit_i, busy_o;
   logic [N-1:0] req_rx_i, req_credit_o, grant_o;
   logic [W-1:0] req_data_i [N];
   logic [W-1:0] data_o;
   logic [15:0] pkt_cnt_o;
   int tests = 0, fails = 0, npk = 0;
   always #5 clk_i = ~clk_i;

   hermes_inject_arbiter #(.NUM_REQ(N), .FLIT_SIZE(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_rx_i(req_rx_i), .req_data_i(req_data_i),
      .req_credit_o(req_credit_o), .rx_o(rx_o), .data_o(data_o), .credit_i(credit_i),
      .grant_o(grant_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
   );

   typedef struct packed {
      logic rst_n; logic [3:0] rx; logic [3:0][31:0] d; logic cr;
      logic [3:0] g; logic rxo; logic [31:0] dout; logic [3:0] rc; logic busy; logic [15:0] cnt;
   } vec_t;
   typedef struct packed {logic hdr; logic [31:0] d;} flit_t;

   flit_t drvq [N][$];
   logic [31:0] allf [N][$];
   int plen [N][$];
   logic [31:0] expq [$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic vec_t mk(logic rst_n, logic [3:0] rx, logic [31:0] d0, d1, d2, logic cr,
                               logic [3:0] g, logic rxo, logic [31:0] dout, logic [3:0] rc,
                               logic busy, logic [15:0] cnt);
      vec_t v;
      v.rst_n = rst_n; v.rx = rx; v.d = {32'hD3D3_0003, d2, d1, d0}; v.cr = cr;
      v.g = g; v.rxo = rxo; v.dout = dout; v.rc = rc; v.busy = busy; v.cnt = cnt;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string nm);
      @(posedge clk_i); #1;
      rst_ni = v.rst_n; req_rx_i = v.rx; credit_i = v.cr;
      for (int i = 0; i < N; i++) req_data_i[i] = v.d[i];
      @(negedge clk_i);
      chk({nm, ".grant"}, 32'(grant_o), 32'(v.g));
      chk({nm, ".rx"}, 32'(rx_o), 32'(v.rxo));
      chk({nm, ".data"}, data_o, v.dout);
      chk({nm, ".credit"}, 32'(req_credit_o), 32'(v.rc));
      chk({nm, ".busy"}, 32'(busy_o), 32'(v.busy));
      chk({nm, ".pkt_cnt"}, 32'(pkt_cnt_o), 32'(v.cnt));
   endtask

   function automatic void gen(int s, int sz, logic [31:0] hdr);
      flit_t f;
      logic [31:0] p;
      f.hdr = 1'b1; f.d = hdr; drvq[s].push_back(f); allf[s].push_back(hdr);
      f.hdr = 1'b0; f.d = 32'(sz); drvq[s].push_back(f); allf[s].push_back(32'(sz));
      for (int k = 0; k < sz; k++) begin
         p = $urandom();
         f.d = p; drvq[s].push_back(f); allf[s].push_back(p);
      end
      plen[s].push_back(sz + 2);
      npk++;
   endfunction

   // whole packets, served round-robin among sources that still have packets queued
   function automatic void model();
      int ptr = 0, s, len;
      while (1) begin
         s = -1;
         for (int k = 0; k < N; k++)
            if (s < 0 && plen[(ptr + k) % N].size() > 0) s = (ptr + k) % N;
         if (s < 0) break;
         len = plen[s].pop_front();
         repeat (len) expq.push_back(allf[s].pop_front());
         ptr = (s + 1) % N;
      end
   endfunction

   task automatic scenario(input string nm, input int stall_pct, input int nocred_pct);
      logic [N-1:0] fire, gprev;
      logic done;
      int cyc;
      expq.delete();
      model();
      @(posedge clk_i); #1;
      rst_ni = 1'b0; req_rx_i = '0; credit_i = 1'b1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      gprev = '0; cyc = 0; done = 1'b0;
      while (!done) begin
         for (int s = 0; s < N; s++)
            if (drvq[s].size() > 0) begin
               req_data_i[s] = drvq[s][0].d;
               req_rx_i[s] = drvq[s][0].hdr || ($urandom_range(99) >= stall_pct);
            end else begin
               req_data_i[s] = $urandom();
               req_rx_i[s] = 1'b0;
            end
         credit_i = $urandom_range(99) >= nocred_pct;
         @(negedge clk_i);
         fire = req_credit_o & req_rx_i;
         if (rx_o && credit_i) begin
            if (expq.size() == 0) chk({nm, ".extra_flit"}, data_o, 32'hxxxx_xxxx);
            else chk({nm, ".flit"}, data_o, expq.pop_front());
         end
         chk({nm, ".onehot"}, 32'($onehot0(grant_o)), 32'd1);
         chk({nm, ".stray_credit"}, 32'(req_credit_o & ~grant_o), 32'd0);
         chk({nm, ".bubble"}, 32'(gprev != '0 && grant_o != '0 && grant_o != gprev), 32'd0);
         gprev = grant_o;
         @(posedge clk_i); #1;
         for (int s = 0; s < N; s++) if (fire[s]) void'(drvq[s].pop_front());
         done = 1'b1;
         for (int s = 0; s < N; s++) if (drvq[s].size() > 0) done = 1'b0;
         if (++cyc > 4000) begin
            chk({nm, ".timeout"}, 32'(cyc), 32'd4000);
            done = 1'b1;
         end
      end
      chk({nm, ".left_over"}, 32'(expq.size()), 32'd0);
      chk({nm, ".pkt_cnt"}, 32'(pkt_cnt_o), 32'(npk));
      chk({nm, ".idle"}, 32'(busy_o), 32'd0);
      for (int s = 0; s < N; s++) begin
         drvq[s].delete(); allf[s].delete(); plen[s].delete();
      end
   endtask

   vec_t tv [$];
   vec_t hv [$];

   initial begin
      rst_ni = 1'b0; req_rx_i = '0; credit_i = 1'b1;
      for (int i = 0; i < N; i++) req_data_i[i] = '0;
      repeat (2) @(posedge clk_i);
      // single packet from req 1 with credit and source stalls, then a zero-length packet
      tv.push_back(mk(0, 4'b0000, K0, 0,     K2, 1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h1203, K2, 1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h1203, K2, 1, 4'b0010, 1, 'h1203, 4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0010, K0, 3,     K2, 1, 4'b0010, 1, 3,     4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h11,  K2, 1, 4'b0010, 1, 'h11,  4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h22,  K2, 0, 4'b0010, 1, 'h22,  4'b0000, 1, 0));
      tv.push_back(mk(1, 4'b0000, K0, 'h22,  K2, 1, 4'b0010, 0, 'h22,  4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h22,  K2, 1, 4'b0010, 1, 'h22,  4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0010, K0, 'h33,  K2, 1, 4'b0010, 1, 'h33,  4'b0010, 1, 0));
      tv.push_back(mk(1, 4'b0000, K0, 0,     K2, 1, 4'b0000, 0, 0,     4'b0000, 0, 1));
      tv.push_back(mk(1, 4'b0010, K0, 'hAB,  K2, 1, 4'b0000, 0, 0,     4'b0000, 0, 1));
      tv.push_back(mk(1, 4'b0010, K0, 'hAB,  K2, 1, 4'b0010, 1, 'hAB,  4'b0010, 1, 1));
      tv.push_back(mk(1, 4'b0010, K0, 0,     K2, 1, 4'b0010, 1, 0,     4'b0010, 1, 1));
      tv.push_back(mk(1, 4'b0000, K0, 0,     K2, 1, 4'b0000, 0, 0,     4'b0000, 0, 2));
      foreach (tv[i]) apply(tv[i], $sformatf("tbl%0d", i));
      // owner 0 stalls while req 2 waits; then reset during req 2's payload
      hv.push_back(mk(0, 4'b0000, 0,     K1,    0,     1, 4'b0000, 0, 0,     4'b0000, 0, 2));
      hv.push_back(mk(0, 4'b0000, 0,     K1,    0,     1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      hv.push_back(mk(1, 4'b0101, 'hA0,  K1,    'hC2,  1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      hv.push_back(mk(1, 4'b0101, 'hA0,  K1,    'hC2,  1, 4'b0001, 1, 'hA0,  4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0101, 2,     K1,    'hC2,  1, 4'b0001, 1, 2,     4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0100, 'hA1,  K1,    'hC2,  1, 4'b0001, 0, 'hA1,  4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0100, 'hA1,  K1,    'hC2,  1, 4'b0001, 0, 'hA1,  4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0101, 'hA1,  K1,    'hC2,  1, 4'b0001, 1, 'hA1,  4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0101, 'hA2,  K1,    'hC2,  1, 4'b0001, 1, 'hA2,  4'b0001, 1, 0));
      hv.push_back(mk(1, 4'b0100, 0,     K1,    'hC2,  1, 4'b0000, 0, 0,     4'b0000, 0, 1));
      hv.push_back(mk(1, 4'b0100, 0,     K1,    'hC2,  1, 4'b0100, 1, 'hC2,  4'b0100, 1, 1));
      hv.push_back(mk(1, 4'b0100, 0,     K1,    5,     1, 4'b0100, 1, 5,     4'b0100, 1, 1));
      hv.push_back(mk(1, 4'b0100, 0,     K1,    'hD5,  1, 4'b0100, 1, 'hD5,  4'b0100, 1, 1));
      hv.push_back(mk(0, 4'b0100, 0,     K1,    'hD5,  1, 4'b0100, 1, 'hD5,  4'b0100, 1, 1));
      hv.push_back(mk(0, 4'b0011, 'hE0,  'hE1,  0,     1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      hv.push_back(mk(1, 4'b0011, 'hE0,  'hE1,  0,     1, 4'b0000, 0, 0,     4'b0000, 0, 0));
      hv.push_back(mk(1, 4'b0011, 'hE0,  'hE1,  0,     1, 4'b0001, 1, 'hE0,  4'b0001, 1, 0));
      foreach (hv[i]) apply(hv[i], $sformatf("seq%0d", i));
      npk = 0;
      for (int s = 0; s < N; s++) gen(s, 2, {16'hC0DE, 16'(s)});
      scenario("simul", 0, 0);
      for (int r = 0; r < 3; r++) begin
         npk = 0;
         for (int s = 0; s < N; s++)
            repeat ($urandom_range(2, 5)) gen(s, $urandom_range(0, 6), $urandom());
         scenario($sformatf("rand%0d", r), 30, 25);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
